// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding and width/slice helpers.
package reg_bank_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // Index width for n items; never below one bit so single-entry cases stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB position of field idx in a packed vector of w-bit fields.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_priority_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping modulo N.
module rr_priority_pick
  import reg_bank_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < int'(N); k++) begin
      cand = int'(ptr) + k;
      if (cand >= int'(N)) cand = cand - int'(N);
      if (!found && req[IW'(cand)]) begin
        found            = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        idx              = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter with locked bursts in front of an internal register bank,
// plus a one-cycle-latency read port.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned AW    = idx_w(DEPTH),
  localparam int unsigned OW    = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*AW-1:0]    wr_addr,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       gnt,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   owned,
  output logic [OW-1:0]          owner
);

  logic [0:0]       state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             wr_en;
  logic [OW-1:0]    wr_sel;
  logic [N_REQ-1:0] pick_gnt;
  logic [OW-1:0]    pick_idx;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [AW-1:0]    addr_arr [N_REQ];
  logic [WIDTH-1:0] data_arr [N_REQ];

  // Unpack per-requester address/data fields.
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
    assign addr_arr[i] = wr_addr[slice_lsb(i, AW) +: AW];
    assign data_arr[i] = wr_data[slice_lsb(i, WIDTH) +: WIDTH];
  end

  rr_priority_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Next-state, grant and write-select decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt     = '0;
    wr_en   = 1'b0;
    wr_sel  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt    = pick_gnt;
          wr_en  = 1'b1;
          wr_sel = pick_idx;
          ptr_d  = (pick_idx == OW'(N_REQ - 1)) ? '0 : pick_idx + OW'(1);
          if (lock[pick_idx]) begin
            state_d = ST_OWNED;
            owner_d = pick_idx;
          end
        end
      end
      default: begin
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          wr_en        = 1'b1;
          wr_sel       = owner_q;
          if (!lock[owner_q]) begin
            state_d = ST_IDLE;
            owner_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
          owner_d = '0;
        end
      end
    endcase
    // Grant must be quiet while reset is held, even before the flops have settled.
    if (rst) begin
      gnt   = '0;
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rd_data <= '0;
      for (int i = 0; i < int'(DEPTH); i++) bank[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rd_data <= bank[rd_addr];
      if (wr_en) bank[addr_arr[wr_sel]] <= data_arr[wr_sel];
    end
  end

  assign owned = (state_q == ST_OWNED);
  assign owner = owner_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized bench for reg_bank_arbiter against a behavioural model.
module tb_reg_bank_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 3;
  localparam int AW = 2;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, lock, gnt;
  logic [N*AW-1:0] wr_addr;
  logic [N*W-1:0]  wr_data;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;
  logic            owned;
  logic [OW-1:0]   owner;

  int tests = 0;
  int fails = 0;

  // Model: bank contents, rotating start point, owning requester (-1 = none).
  int m_bank [D];
  int m_ptr;
  int m_own;
  int a [N];
  int d [N];

  reg_bank_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .owned   (owned),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_bank[i] = 0;
    m_ptr = 0;
    m_own = -1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = AW'(a[i]);
      wr_data[i*W +: W]   = W'(d[i]);
    end
  endtask

  // One clock: check grant/ownership mid-cycle, read data after the edge, then advance the model.
  task automatic cycle(input string tag);
    int w;
    int exp_rd;
    pack();
    #2;
    w = -1;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end else if (req[m_own]) begin
      w = m_own;
    end
    chk({tag, ":gnt"}, 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
    chk({tag, ":owned"}, 32'(owned), (m_own >= 0) ? 32'd1 : 32'd0);
    chk({tag, ":owner"}, 32'(owner), (m_own >= 0) ? 32'(m_own) : 32'd0);
    exp_rd = m_bank[rd_addr];
    @(posedge clk);
    #1;
    chk({tag, ":rd_data"}, 32'(rd_data), 32'(exp_rd));
    if (w >= 0) begin
      m_bank[a[w]] = d[w];
      if (m_own < 0) begin
        m_ptr = (w + 1) % N;
        if (lock[w]) m_own = w;
      end else if (!lock[w]) begin
        m_own = -1;
      end
    end else if (m_own >= 0) begin
      m_own = -1;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '1;
    lock = '0;
    rd_addr = '0;
    for (int i = 0; i < N; i++) begin a[i] = i; d[i] = i; end
    pack();
    model_reset();
    #3;
    chk("rst:gnt", 32'(gnt), 32'd0);
    chk("rst:owned", 32'(owned), 32'd0);
    chk("rst:owner", 32'(owner), 32'd0);
    chk("rst:rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;

    // Reset contents read back as zero.
    for (int i = 0; i < D; i++) begin rd_addr = AW'(i); cycle("rd0"); end

    // Single writer then read-back.
    req = 4'b0100; a[2] = 1; d[2] = 5;
    cycle("single_wr");
    req = '0; rd_addr = 2'd1;
    cycle("single_rd0");
    cycle("single_rd1");
    chk("single_val", 32'(rd_data), 32'd5);

    // All requesting: rotation and pointer wrap.
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin a[i] = i; d[i] = (c + i) % 8; end
      rd_addr = AW'(c % D);
      cycle("rr");
    end

    // Park the pointer at 1, then a locked burst from requester 1 with competitors.
    req = 4'b0001; a[0] = 3; d[0] = 7;
    cycle("park");
    req = 4'b1011; lock = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) lock = '0;
      a[1] = c; d[1] = c + 2;
      cycle("burst");
    end
    cycle("post_burst");
    chk("post_burst_owner3", 32'(m_ptr), 32'd0);
    req = '0;

    // Read/write collision on address 0.
    req = 4'b0001; a[0] = 0; d[0] = 6;
    cycle("coll_pre");
    d[0] = 1; rd_addr = 2'd0;
    cycle("coll_same");
    req = '0;
    cycle("coll_next");
    chk("coll_val", 32'(rd_data), 32'd1);

    // Reset while a burst is in progress.
    req = 4'b0100; lock = 4'b0100; a[2] = 2; d[2] = 3;
    cycle("mid_b0");
    cycle("mid_b1");
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst:owned", 32'(owned), 32'd0);
    chk("mid_rst:gnt", 32'(gnt), 32'd0);
    chk("mid_rst:rd_data", 32'(rd_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0; lock = '0;
    for (int i = 0; i < D; i++) begin rd_addr = AW'(i); cycle("rd_after_rst"); end

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      req  = N'($urandom_range(0, 15));
      lock = N'($urandom & $urandom);
      rd_addr = AW'($urandom_range(0, D - 1));
      for (int i = 0; i < N; i++) begin
        a[i] = $urandom_range(0, D - 1);
        d[i] = $urandom_range(0, 7);
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Round-robin write arbiter and controller for a small bank of WIDTH-bit registers shared by N_REQ requesters.
- Grants at most one write per cycle and supports locked multi-cycle ownership for bursts.
- Provides one registered read port.
- Sits between requesting datapath blocks and the storage registers; the bank is internal to this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DEPTH, 4, number of registers in the bank (power of 2).
- WIDTH, 3, bits per register.
- AW, localparam = log2(DEPTH), address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester write request, held until granted.
- lock  input  N_REQ  per-requester ownership hold; sampled only with req.
- wr_addr  input  N_REQ*AW  packed write addresses; requester i at slice [i*AW +: AW].
- wr_data  input  N_REQ*WIDTH  packed write data; requester i at slice [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant, combinational, same cycle as the accepted req.
- rd_addr  input  AW  read address.
- rd_data  output  WIDTH  registered read data.
- owned  output  1  high while in state OWNED.
- owner  output  log2(N_REQ)  current owner index; valid when owned=1, else 0.

Behaviour:
Reset (asynchronous, active-high):
- All bank entries = 0, rd_data = 0, rr pointer = 0, state = IDLE, owner = 0, owned = 0.
- gnt = 0 while rst is high.

FSM states: IDLE and OWNED.

IDLE:
- Winner = first i with req[i]=1, scanning from the rr pointer upward modulo N_REQ.
- gnt[winner]=1 combinationally.
- At the clock edge: bank[wr_addr_winner] <= wr_data_winner; rr pointer <= (winner+1) mod N_REQ.
- If lock[winner]=1, go to OWNED with owner <= winner; otherwise stay in IDLE.
- No req: gnt=0, no write, pointer unchanged.

OWNED:
- Only the owner can be granted; other reqs are ignored (gnt stays 0 for them, no starvation counter).
- req[owner]=1: gnt[owner]=1 and the write commits at the edge; rr pointer unchanged.
- Go to IDLE at the edge where req[owner]=1 and lock[owner]=0 (final burst write still commits), or where req[owner]=0 (no write).

Handshake:
- A requester sees gnt in the same cycle it drives req.
- A write is accepted exactly when req[i] and gnt[i] are both high at the edge.
- The requester must change its data or drop req on the next cycle.

Grant and write rules:
- At most one gnt bit is high at any time.
- Exactly one bank entry is written per granted cycle.

Read port:
- rd_data <= bank[rd_addr] at every edge, giving 1-cycle latency.
- Same-address read and write in one cycle returns the pre-write value; the new value is visible one cycle later.

Boundaries:
- rr pointer wraps N_REQ-1 -> 0.
- An out-of-range wr_addr cannot occur because DEPTH is a power of 2.
- Reset asserted mid-burst: immediate return to IDLE, bank cleared, the pending write is discarded.
- A lock without req is ignored.

Decomposition:
- Shared package: AW and owner-width helper (clog2), state encoding IDLE=1'b0 and OWNED=1'b1, packed-slice helper constants.
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Reusable by other arbiters.
- FSM, bank and read register stay in the top level.

Test Plan:
1. Reset then read all addresses: rst pulse, rd_addr 0..3 -> rd_data=3'b000 each cycle after; gnt=0 during rst.
2. Single writer, write then read:
   - req[2]=1, addr 1, data 3'b101 -> gnt=4'b0100 same cycle.
   - rd_addr=1 next cycle -> rd_data=3'b101 one cycle later.
3. Round-robin fairness:
   - req=4'b1111 held with distinct data for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...
   - Pointer wraps 3->0.
4. Locked burst:
   - req[1]=1, lock[1]=1 for 3 cycles, then lock[1]=0 on the 4th, with req[0] and req[3] also high.
   - Expect gnt=0010 for 4 cycles, owned=1, owner=1 for cycles 2-4.
   - Then IDLE; next grant goes to requester 3.
5. Read/write collision:
   - addr 0 holds 3'b110; write 3'b001 to addr 0 with rd_addr=0 in the same cycle -> rd_data=3'b110.
   - Next read returns 3'b001.
6. Reset mid-burst: assert rst asynchronously while OWNED -> owned=0, gnt=0 immediately, bank reads 3'b000 after release.
